// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative shift-add MUL/MLA, BITS_PER_CYCLE multiplier bits per cycle, low 32-bit result.
// Optional N/Z flag outputs are enabled by defining MUL_ITER_FLAGS_EN.
module mul_iter_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        accumulate,
    input  logic [31:0] rn_data,
    input  logic [31:0] rm_data,
    input  logic [31:0] ra_data,
    input  logic [3:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  rd_out
`ifdef MUL_ITER_FLAGS_EN
    ,
    input  logic        setflags,
    output logic        flag_n,
    output logic        flag_z
`endif
);
    localparam int ITER = 32 / BITS_PER_CYCLE;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      r_state;
    logic [31:0] r_mcand, r_mplier, r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] w_digit, w_acc_next;
    logic        w_load, w_last;
    assign w_digit    = {{(32-BITS_PER_CYCLE){1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};
    assign w_acc_next = r_acc + r_mcand * w_digit;
    assign w_load     = start && (r_state != CALC);
    assign w_last     = (r_state == CALC) && (r_cnt == 5'd0);
    assign busy       = r_state == CALC;
    assign done       = r_state == DONE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            result   <= '0;
            rd_out   <= '0;
        end else if (w_load) begin
            r_mcand  <= rn_data;
            r_mplier <= rm_data;
            r_acc    <= accumulate ? ra_data : 32'd0;
            rd_out   <= rd_in;
            r_cnt    <= 5'(ITER - 1);
            r_state  <= CALC;
        end else if (r_state == CALC) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            if (r_cnt == 5'd0) begin
                result  <= w_acc_next;
                r_state <= DONE;
            end else begin
                r_cnt <= r_cnt - 5'd1;
            end
        end else begin
            r_state <= IDLE;
        end
    end
`ifdef MUL_ITER_FLAGS_EN
    logic r_setflags;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_setflags <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
        end else begin
            if (w_load) r_setflags <= setflags;
            if (w_last && r_setflags) begin
                flag_n <= w_acc_next[31];
                flag_z <= w_acc_next == 32'd0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: directed checks of mul_iter_unit for BITS_PER_CYCLE = 1, 2, 4, 8 sharing one operand bus.
module tb_mul_iter_unit;
    logic        clk = 1'b0, reset = 1'b1, accumulate = 1'b0, setflags = 1'b0;
    logic [3:0]  start_v = 4'h0, rd_in = 4'h0;
    logic [31:0] rn = '0, rm = '0, ra = '0;
    logic        busy_v[4], done_v[4];
    logic [31:0] res_v[4];
    logic [3:0]  rdo_v[4];
`ifdef MUL_ITER_FLAGS_EN
    logic        fn_v[4], fz_v[4];
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mul_iter_unit #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clk(clk), .reset(reset), .start(start_v[g]), .accumulate(accumulate),
            .rn_data(rn), .rm_data(rm), .ra_data(ra), .rd_in(rd_in),
            .busy(busy_v[g]), .done(done_v[g]), .result(res_v[g]), .rd_out(rdo_v[g])
`ifdef MUL_ITER_FLAGS_EN
            , .setflags(setflags), .flag_n(fn_v[g]), .flag_z(fz_v[g])
`endif
        );
    end

    task automatic launch(input int k, input bit now, input logic a, input logic [31:0] n, m, r, input logic [3:0] d);
        if (!now) @(negedge clk);
        accumulate = a; rn = n; rm = m; ra = r; rd_in = d; start_v[k] = 1'b1;
        @(posedge clk);
        #1 start_v[k] = 1'b0;
    endtask

    // edges counts the start edge too; -1 means done never came
    task automatic wait_done(input int k, output int edges, output int busy_cnt);
        edges = -1; busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_v[k]) begin edges = i + 1; break; end
            if (busy_v[k]) busy_cnt++;
            @(posedge clk);
        end
    endtask

    task automatic count_dones(input int k, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin @(negedge clk); if (done_v[k] || busy_v[k]) n++; end
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || res_v[k] !== 32'd0 || rdo_v[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset[%0d]: busy=%b done=%b result=%h rd=%h, required all zero", k, busy_v[k], done_v[k], res_v[k], rdo_v[k]);
            end
        end
`ifdef MUL_ITER_FLAGS_EN
        checks++;
        if (fn_v[0] !== 1'b0 || fz_v[0] !== 1'b0) begin errors++; $display("FAIL reset_flags: n=%b z=%b, required 0 0", fn_v[0], fz_v[0]); end
`endif
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_mul_basic;
        int e, b;
        launch(0, 0, 1'b0, 32'd7, 32'd6, 32'd99, 4'h5);
        wait_done(0, e, b);
        checks++; if (e !== 33) begin errors++; $display("FAIL mul_latency: got %0d edges, required 33", e); end
        checks++; if (b !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d, required 32", b); end
        checks++; if (res_v[0] !== 32'd42) begin errors++; $display("FAIL mul_result: got %h, required %h", res_v[0], 32'd42); end
        checks++; if (rdo_v[0] !== 4'h5) begin errors++; $display("FAIL mul_rd: got %h, required 5", rdo_v[0]); end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b0 || res_v[0] !== 32'd42) begin errors++; $display("FAIL mul_done_pulse: done=%b result=%h, required 0 and 2a", done_v[0], res_v[0]); end
    endtask

    task automatic test_mla;
        logic [31:0] tn[3] = '{32'd3, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] tm[3] = '{32'd4, 32'hFFFFFFFF, 32'd2};
        logic [31:0] ta[3] = '{32'd5, 32'd0, 32'd0};
        logic [31:0] tr[3] = '{32'd17, 32'h00000001, 32'h00000000};
        int e, b;
        for (int i = 0; i < 3; i++) begin
            launch(0, 0, 1'b1, tn[i], tm[i], ta[i], 4'(i + 8));
            wait_done(0, e, b);
            checks++;
            if (e !== 33 || res_v[0] !== tr[i]) begin
                errors++;
                $display("FAIL mla[%0d]: got result %h after %0d edges, required %h after 33", i, res_v[0], e, tr[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int e, b, n;
        launch(0, 0, 1'b0, 32'd7, 32'd6, 32'd0, 4'h1);
        wait_done(0, e, b);
        launch(0, 1, 1'b0, 32'd2, 32'd9, 32'd0, 4'h2);
        wait_done(0, e, b);
        checks++; if (e !== 33 || b !== 32) begin errors++; $display("FAIL b2b_latency: got %0d edges %0d busy, required 33 and 32", e, b); end
        checks++; if (res_v[0] !== 32'd18 || rdo_v[0] !== 4'h2) begin errors++; $display("FAIL b2b_result: got %h rd %h, required 12 rd 2", res_v[0], rdo_v[0]); end
        launch(0, 0, 1'b0, 32'd3, 32'd3, 32'd0, 4'h3);
        repeat (3) begin
            @(negedge clk);
            rn = 32'd100; rm = 32'd100; rd_in = 4'hE; accumulate = 1'b1; start_v[0] = 1'b1;
            @(posedge clk);
            #1 start_v[0] = 1'b0;
        end
        wait_done(0, e, b);
        checks++; if (e !== 30) begin errors++; $display("FAIL busy_ignore_latency: got %0d, required 30", e); end
        checks++; if (res_v[0] !== 32'd9 || rdo_v[0] !== 4'h3) begin errors++; $display("FAIL busy_ignore_result: got %h rd %h, required 9 rd 3", res_v[0], rdo_v[0]); end
        count_dones(0, 40, n);
        checks++; if (n !== 0 || res_v[0] !== 32'd9) begin errors++; $display("FAIL busy_ignore_extra: got %0d busy/done cycles result %h, required 0 and 9", n, res_v[0]); end
    endtask

    task automatic test_async_reset;
        int e, b, n;
        launch(0, 0, 1'b0, 32'd7, 32'd6, 32'd0, 4'h5);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || res_v[0] !== 32'd0 || rdo_v[0] !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b result=%h rd=%h, required all zero", busy_v[0], done_v[0], res_v[0], rdo_v[0]);
        end
        @(negedge clk) reset = 1'b1;
        count_dones(0, 40, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL async_reset_idle: got %0d busy/done cycles, required 0", n); end
        launch(0, 0, 1'b0, 32'd7, 32'd6, 32'd0, 4'h5);
        wait_done(0, e, b);
        checks++; if (e !== 33 || res_v[0] !== 32'd42) begin errors++; $display("FAIL async_reset_rerun: got %h after %0d edges, required 2a after 33", res_v[0], e); end
    endtask

    task automatic test_sweep;
        int e, b;
        logic [31:0] n, m, r, x;
        logic a;
        launch(2, 0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'd0, 4'h6);
        wait_done(2, e, b);
        checks++; if (e !== 9 || b !== 8) begin errors++; $display("FAIL sweep4_latency: got %0d edges %0d busy, required 9 and 8", e, b); end
        checks++; if (res_v[2] !== 32'h242D2080) begin errors++; $display("FAIL sweep4_result: got %h, required 242d2080", res_v[2]); end
        for (int t = 0; t < 4; t++) begin
            n = $urandom; m = $urandom; r = $urandom; a = t[0];
            x = n * m + (a ? r : 32'd0);
            @(negedge clk);
            accumulate = a; rn = n; rm = m; ra = r; rd_in = 4'(t); start_v = 4'hF;
            @(posedge clk);
            #1 start_v = 4'h0;
            repeat (40) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (res_v[k] !== x || rdo_v[k] !== 4'(t)) begin
                    errors++;
                    $display("FAIL sweep_rand[%0d] bpc=%0d: got %h rd %h, required %h rd %h", t, 1 << k, res_v[k], rdo_v[k], x, 4'(t));
                end
            end
        end
    endtask

`ifdef MUL_ITER_FLAGS_EN
    task automatic test_flags;
        int e, b;
        setflags = 1'b1;
        launch(0, 0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'h1);
        wait_done(0, e, b);
        checks++; if (fn_v[0] !== 1'b1 || fz_v[0] !== 1'b0) begin errors++; $display("FAIL flags_neg: n=%b z=%b, required 1 0", fn_v[0], fz_v[0]); end
        launch(0, 0, 1'b0, 32'd0, 32'd123, 32'd0, 4'h1);
        wait_done(0, e, b);
        checks++; if (fn_v[0] !== 1'b0 || fz_v[0] !== 1'b1) begin errors++; $display("FAIL flags_zero: n=%b z=%b, required 0 1", fn_v[0], fz_v[0]); end
        setflags = 1'b0;
        launch(0, 0, 1'b0, 32'd5, 32'd5, 32'd0, 4'h1);
        wait_done(0, e, b);
        checks++;
        if (fn_v[0] !== 1'b0 || fz_v[0] !== 1'b1 || res_v[0] !== 32'd25) begin
            errors++;
            $display("FAIL flags_hold: n=%b z=%b result=%h, required 0 1 19", fn_v[0], fz_v[0], res_v[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mul_basic();
        test_mla();
        test_back_to_back();
        test_async_reset();
        test_sweep();
`ifdef MUL_ITER_FLAGS_EN
        test_flags();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
